mbist_fail_log: RTL and testbench
=================================

# mbist_fail_log

Failure logger for the memory BIST datapath, downstream of the BIST top level. Each qualified compare cycle, it samples the BIST test address (TAS), the expected data (TDS), the memory read data and the pass/fail result. Failing compares go into a small FIFO, with a saturating fail counter, a first-fail address register and a sticky overflow flag. A tester or host drains the FIFO through a valid/ready handshake and reads a test-level pass/done summary.

## Interface
- `aw`, default `ADDR_WIDTH`: TAS address width.
- `dw`, default `DATA_WIDTH`: data width (expected and actual).
- `depth`, default 8: FIFO entries; power of two, at least 2.
- `cw`, default 8: fail counter width.

- `clk` in, 1: clock; all state changes on the rising edge.
- `rst` in, 1: asynchronous active-low reset.
- `en_in` in, 1: test active; from the BIST run enable.
- `clr_in` in, 1: synchronous clear of all log state; has priority over everything except `rst`.
- `cmp_valid_in` in, 1: this cycle is a read-compare cycle.
- `passfail_in` in, 1: comparator result; 1 = mismatch (fail).
- `tas_in` in, `aw`: address of the compared location.
- `exp_in` in, `dw`: expected data (TDS).
- `act_in` in, `dw`: memory read data.
- `rd_ready_in` in, 1: consumer accepts the head entry.
- `rd_valid_out` out, 1: head entry is available.
- `rd_addr_out` out, `aw`: head entry address.
- `rd_exp_out` out, `dw`: head entry expected data.
- `rd_act_out` out, `dw`: head entry actual data.
- `fail_cnt_out` out, `cw`: number of failures, saturating.
- `first_addr_out` out, `aw`: address of the first failure since clear.
- `first_vld_out` out, 1: `first_addr_out` is valid.
- `ovf_out` out, 1: sticky; at least one failure was not stored.
- `done_out` out, 1: test finished; the summary is frozen.
- `pass_out` out, 1: `done_out` is high and `fail_cnt_out` is 0.

## Operation
**State machine:** IDLE, RUN, DONE.
- IDLE to RUN: `en_in`=1.
- RUN to DONE: `en_in`=0.
- DONE to RUN: `en_in`=1. The log is not cleared, so failures accumulate.
- Any state to IDLE: `clr_in`=1, which also empties the FIFO, zeroes the counter and clears `first_vld_out` and `ovf_out`.

**Capture:**
- A capture happens only when state is RUN, `cmp_valid_in`=1 and `passfail_in`=1. Compares in IDLE or DONE, or compares with `passfail_in`=0, are ignored.
- Each capture does three things:
  - pushes {`tas_in`, `exp_in`, `act_in`} into the FIFO;
  - increments `fail_cnt_out`, which saturates at 2^`cw`-1;
  - loads `first_addr_out` and sets `first_vld_out`, but only if `first_vld_out`=0.

**FIFO:**
- Circular buffer of `depth` entries, with read/write pointers one bit wider than the index so full and empty can be distinguished.
- Pop occurs when `rd_valid_out`=1 and `rd_ready_in`=1.
- Full with no pop in the same cycle: the captured entry is dropped and `ovf_out` is set. The counter and first-fail logic still update.
- Full with a pop in the same cycle: push and pop both occur and the occupancy stays `depth`.
- Empty: `rd_ready_in` is ignored; `rd_valid_out` is 0 and the head data outputs are don't-care.
- Pointers wrap modulo `depth`.
- Draining is allowed in every state, including IDLE after a run. Only `clr_in` or `rst` discards entries.

**Summary outputs:**
- `done_out` = (state == DONE).
- `pass_out` = `done_out` AND `fail_cnt_out` == 0.

## Timing
- **Reset values:** all outputs 0. State IDLE, FIFO empty, counter 0.
- **Capture latency:** a failing compare in cycle N gives, in cycle N+1:
  - `rd_valid_out`=1 if the FIFO was empty;
  - `fail_cnt_out` updated;
  - `first_addr_out` updated if it was the first failure.
- **Pop:** the next head entry is presented in the cycle after the pop. There is no bubble when several entries are queued.
- **Simultaneous push and pop on an empty FIFO:** not possible, because `rd_valid_out` is 0; the entry appears at N+1.
- **Clear timing:** `clr_in` in cycle N gives cleared state in cycle N+1. A failing compare or pop in cycle N is discarded.
- **End of run:** `en_in` falling at cycle N gives `done_out`=1 at N+1. A compare in cycle N is still captured, because the state was RUN.
- **Reset mid-run:** `rst` low clears everything immediately. The FIFO contents are lost and outputs take their reset values without waiting for a clock.

## Test plan
- **Clean run.** Reset, `en_in`=1 for 20 cycles with `cmp_valid_in`=1 and `passfail_in`=0, then `en_in`=0. Expect `done_out`=1 and `pass_out`=1 one cycle later, `fail_cnt_out`=0 and `rd_valid_out`=0.
- **Single fail.** Fail at `tas_in`=0x05, `exp_in`=0xAA, `act_in`=0xAB. Next cycle expect:
  - `rd_valid_out`=1 with head {0x05, 0xAA, 0xAB};
  - `first_addr_out`=0x05, `first_vld_out`=1;
  - `fail_cnt_out`=1.
  After `en_in` falls, expect `pass_out`=0.
- **Overflow.** With `depth`=8, inject 10 fails at addresses 0..9 with `rd_ready_in`=0. Expect:
  - `fail_cnt_out`=10 and `ovf_out`=1;
  - draining returns addresses 0..7 in order, then `rd_valid_out`=0;
  - `first_addr_out`=0.
- **Full plus simultaneous pop.** Fill to 8 entries, then hold `rd_ready_in`=1 while injecting one fail per cycle for 4 cycles. Expect `ovf_out` to stay 0, occupancy to stay 8, and output order to be strictly FIFO.
- **Saturation and masking.** With `cw`=4, inject 20 fails and expect `fail_cnt_out`=15. Then apply fails while in IDLE and in DONE, and fails with `cmp_valid_in`=0, and expect no change.
- **Clear and reset.** Assert `clr_in` while a fail and a pop coincide: next cycle everything is 0 and the state is IDLE. Assert `rst` low mid-run: outputs go to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mbist_fail_log.sv
// MBIST failure logger: captures failing compares into a small FIFO and keeps
// a saturating fail count, first-fail address, sticky overflow and pass/done summary.
module mbist_fail_log #(
  parameter int unsigned aw    = 8,
  parameter int unsigned dw    = 8,
  parameter int unsigned depth = 8,
  parameter int unsigned cw    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic          clr_in,
  input  logic          cmp_valid_in,
  input  logic          passfail_in,
  input  logic [aw-1:0] tas_in,
  input  logic [dw-1:0] exp_in,
  input  logic [dw-1:0] act_in,
  input  logic          rd_ready_in,
  output logic          rd_valid_out,
  output logic [aw-1:0] rd_addr_out,
  output logic [dw-1:0] rd_exp_out,
  output logic [dw-1:0] rd_act_out,
  output logic [cw-1:0] fail_cnt_out,
  output logic [aw-1:0] first_addr_out,
  output logic          first_vld_out,
  output logic          ovf_out,
  output logic          done_out,
  output logic          pass_out
);

  localparam int unsigned IW = $clog2(depth);
  localparam int unsigned EW = aw + 2 * dw;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [aw-1:0] first_q, first_d;
  logic          first_vld_q, first_vld_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] mem_q [depth];
  logic [EW-1:0] head;

  logic capture, empty, full, pop, push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
  assign capture = (state_q == RUN) && cmp_valid_in && passfail_in && !clr_in;
  assign pop     = !empty && rd_ready_in && !clr_in;
  // A full FIFO still accepts the new entry when the head leaves in the same cycle.
  assign push    = capture && (!full || pop);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    first_vld_d = first_vld_q;
    ovf_d       = ovf_q;
    if (clr_in) begin
      state_d     = IDLE;
      wr_d        = '0;
      rd_d        = '0;
      cnt_d       = '0;
      first_d     = '0;
      first_vld_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (en_in)  state_d = RUN;
        RUN:     if (!en_in) state_d = DONE;
        DONE:    if (en_in)  state_d = RUN;
        default: state_d = IDLE;
      endcase
      if (push) wr_d = wr_q + (IW + 1)'(1);
      if (pop)  rd_d = rd_q + (IW + 1)'(1);
      if (capture) begin
        if (cnt_q != '1) cnt_d = cnt_q + cw'(1);
        if (!first_vld_q) begin
          first_d     = tas_in;
          first_vld_d = 1'b1;
        end
        if (!push) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      first_vld_q <= first_vld_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[IW-1:0]] <= {tas_in, exp_in, act_in};
  end

  assign head           = mem_q[rd_q[IW-1:0]];
  assign rd_valid_out   = !empty;
  assign rd_addr_out    = rd_valid_out ? head[EW-1 -: aw]     : '0;
  assign rd_exp_out     = rd_valid_out ? head[2*dw-1 -: dw]   : '0;
  assign rd_act_out     = rd_valid_out ? head[dw-1:0]         : '0;
  assign fail_cnt_out   = cnt_q;
  assign first_addr_out = first_q;
  assign first_vld_out  = first_vld_q;
  assign ovf_out        = ovf_q;
  assign done_out       = (state_q == DONE);
  assign pass_out       = done_out && (cnt_q == '0);

endmodule

// File: tb/tb_mbist_fail_log.sv
// Scoreboard bench for mbist_fail_log: the driver queues expected FIFO entries,
// a negedge monitor checks every popped head entry in order.
module tb_mbist_fail_log;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_in = 1'b0, clr_in = 1'b0, cmp_valid_in = 1'b0, passfail_in = 1'b0;
  logic [7:0] tas_in = '0, exp_in = '0, act_in = '0;
  logic       rd_ready_in = 1'b0;
  logic       rd_valid_out;
  logic [7:0] rd_addr_out, rd_exp_out, rd_act_out;
  logic [3:0] fail_cnt_out;
  logic [7:0] first_addr_out;
  logic       first_vld_out, ovf_out, done_out, pass_out;

  int checks = 0;
  int errors = 0;
  int mstate = 0;  // 0 IDLE, 1 RUN, 2 DONE
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  mbist_fail_log #(.aw(8), .dw(8), .depth(8), .cw(4)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .clr_in(clr_in),
    .cmp_valid_in(cmp_valid_in), .passfail_in(passfail_in),
    .tas_in(tas_in), .exp_in(exp_in), .act_in(act_in),
    .rd_ready_in(rd_ready_in), .rd_valid_out(rd_valid_out),
    .rd_addr_out(rd_addr_out), .rd_exp_out(rd_exp_out), .rd_act_out(rd_act_out),
    .fail_cnt_out(fail_cnt_out), .first_addr_out(first_addr_out),
    .first_vld_out(first_vld_out), .ovf_out(ovf_out),
    .done_out(done_out), .pass_out(pass_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one cycle and advance the expected-state model.
  task automatic cycle(input bit en, input bit clr, input bit cmpv, input bit pf,
                       input logic [7:0] tas, input logic [7:0] e, input logic [7:0] a,
                       input bit rdy);
    bit cap, pop;
    en_in = en; clr_in = clr; cmp_valid_in = cmpv; passfail_in = pf;
    tas_in = tas; exp_in = e; act_in = a; rd_ready_in = rdy;
    cap = (mstate == 1) && cmpv && pf && !clr;
    pop = (exp_q.size() > 0) && rdy && !clr;
    if (clr) exp_q.delete();
    else if (cap && (exp_q.size() < 8 || pop)) exp_q.push_back({tas, e, a});
    if (clr) mstate = 0;
    else case (mstate)
      0: if (en)  mstate = 1;
      1: if (!en) mstate = 2;
      default: if (en) mstate = 1;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic fail_at(input bit en, input logic [7:0] addr, input bit rdy);
    cycle(en, 1'b0, 1'b1, 1'b1, addr, addr ^ 8'h5A, ~addr, rdy);
  endtask

  task automatic idle(input bit en, input bit rdy);
    cycle(en, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, rdy);
  endtask

  task automatic clear();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst && !clr_in && rd_valid_out && rd_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got addr %0h expected no entry", rd_addr_out);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("pop_entry", 32'({rd_addr_out, rd_exp_out, rd_act_out}), 32'(e));
      end
    end
  end

  initial begin
    #12;
    chk("reset_valid", 32'(rd_valid_out), 0);
    chk("reset_cnt", 32'(fail_cnt_out), 0);
    chk("reset_flags", 32'({first_vld_out, ovf_out, done_out, pass_out}), 0);
    chk("reset_heads", 32'({rd_addr_out, rd_exp_out, rd_act_out}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean run
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'h11, 8'h11, 1'b0);
    idle(1'b0, 1'b0);
    chk("clean_done", 32'(done_out), 1);
    chk("clean_pass", 32'(pass_out), 1);
    chk("clean_cnt", 32'(fail_cnt_out), 0);
    chk("clean_valid", 32'(rd_valid_out), 0);

    // Single fail
    clear();
    idle(1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'hAA, 8'hAB, 1'b0);
    chk("single_valid", 32'(rd_valid_out), 1);
    chk("single_head", 32'({rd_addr_out, rd_exp_out, rd_act_out}), 32'h05AAAB);
    chk("single_first", 32'({first_vld_out, first_addr_out}), 32'h105);
    chk("single_cnt", 32'(fail_cnt_out), 1);
    idle(1'b0, 1'b0);
    chk("single_done", 32'(done_out), 1);
    chk("single_pass", 32'(pass_out), 0);
    idle(1'b0, 1'b1);
    chk("single_drained", 32'(rd_valid_out), 0);

    // Overflow: 10 fails into 8 entries, drain in DONE
    clear();
    idle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) fail_at(1'b1, 8'(i), 1'b0);
    chk("ovf_cnt", 32'(fail_cnt_out), 10);
    chk("ovf_flag", 32'(ovf_out), 1);
    chk("ovf_first", 32'({first_vld_out, first_addr_out}), 32'h100);
    idle(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b0, 1'b1);
    chk("ovf_drained", 32'(rd_valid_out), 0);
    chk("ovf_queue_empty", 32'(exp_q.size()), 0);

    // Full plus simultaneous pop
    clear();
    idle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) fail_at(1'b1, 8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) fail_at(1'b1, 8'h20 + 8'(i), 1'b1);
    chk("fullpop_ovf", 32'(ovf_out), 0);
    chk("fullpop_cnt", 32'(fail_cnt_out), 12);
    for (int i = 0; i < 8; i++) begin
      chk("fullpop_occ", 32'(rd_valid_out), 1);
      idle(1'b1, 1'b1);
    end
    chk("fullpop_empty", 32'(rd_valid_out), 0);

    // Masking: fails in IDLE, with cmp_valid low, and in DONE
    clear();
    fail_at(1'b0, 8'h31, 1'b0);
    chk("mask_idle", 32'({fail_cnt_out, first_vld_out, rd_valid_out}), 0);
    fail_at(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 8'h00, 8'hFF, 1'b0);
    chk("mask_novalid", 32'({fail_cnt_out, first_vld_out, rd_valid_out}), 0);
    idle(1'b0, 1'b0);
    fail_at(1'b0, 8'h34, 1'b0);
    fail_at(1'b0, 8'h35, 1'b0);
    chk("mask_done", 32'({fail_cnt_out, first_vld_out, rd_valid_out}), 0);
    chk("mask_pass", 32'(pass_out), 1);

    // Saturation at 15, DONE to RUN keeps accumulating
    idle(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) fail_at(1'b1, 8'h40 + 8'(i), 1'b0);
    chk("sat_cnt", 32'(fail_cnt_out), 15);
    chk("sat_first", 32'(first_addr_out), 32'h40);

    // Clear coinciding with a fail and a pop
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h00, 8'h01, 1'b1);
    chk("clr_cnt", 32'(fail_cnt_out), 0);
    chk("clr_fifo", 32'(rd_valid_out), 0);
    chk("clr_flags", 32'({first_vld_out, first_addr_out, ovf_out, done_out, pass_out}), 0);
    fail_at(1'b1, 8'h78, 1'b0);
    chk("clr_idle", 32'(fail_cnt_out), 0);

    // Asynchronous reset mid-run
    fail_at(1'b1, 8'h79, 1'b0);
    chk("prerst_cnt", 32'(fail_cnt_out), 1);
    chk("prerst_valid", 32'(rd_valid_out), 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    mstate = 0;
    #1;
    chk("arst_valid", 32'(rd_valid_out), 0);
    chk("arst_cnt", 32'(fail_cnt_out), 0);
    chk("arst_flags", 32'({first_vld_out, first_addr_out, ovf_out, done_out, pass_out}), 0);
    #3;
    rst = 1'b1;
    idle(1'b0, 1'b1);
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
